data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Memory-side responder for the GPU's multi-channel data memory interface. It services per-channel read and write requests issued with valid/ready handshakes and backs them with a single-ported word array. One access per cycle is granted by a round-robin arbiter. The responder answers with a fixed-latency ready pulse-and-hold. It sits at the far end of the data-memory channels, in both the simulation harness and the FPGA build.

## Interface

Parameters:
- NUM_CHANNELS, 8, number of independent request channels (each has a read port and a write port)
- ADDR_WIDTH, 8, word address width; array depth is 2**ADDR_WIDTH words
- DATA_WIDTH, 32, word width
- LATENCY, 2, cycles from grant edge to ready; legal range 1..15

Ports:
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  asynchronous, active-low; clears all control state and outputs
- data_mem_read_valid  in  NUM_CHANNELS  per-channel read request
- data_mem_read_address  in  ADDR_WIDTH x NUM_CHANNELS (unpacked)  read word address
- data_mem_read_ready  out  NUM_CHANNELS  read completed; data valid while high
- data_mem_read_data  out  DATA_WIDTH x NUM_CHANNELS (unpacked)  read result
- data_mem_write_valid  in  NUM_CHANNELS  per-channel write request
- data_mem_write_address  in  ADDR_WIDTH x NUM_CHANNELS (unpacked)  write word address
- data_mem_write_data  in  DATA_WIDTH x NUM_CHANNELS (unpacked)  write word
- data_mem_write_ready  out  NUM_CHANNELS  write committed

## Operation

- There are 2*NUM_CHANNELS requesters. Requester index 2c is the write port of channel c; index 2c+1 is the read port.
- Each requester runs its own FSM:
  - IDLE: ready=0. The port is pending when valid=1.
  - LAT: latency countdown. The counter loads LATENCY-1 at grant and decrements each cycle. It moves to DONE when the counter is 0.
  - DONE: ready=1. Stays in DONE while valid=1. On the edge where valid is sampled 0, it moves to IDLE.
- Arbiter: each cycle it grants at most one pending IDLE requester. The search starts at rr_ptr and runs upward with wrap. On the grant edge, rr_ptr is set to granted index + 1, modulo 2*NUM_CHANNELS.
- Grant actions at the grant edge:
  - Write: mem[addr] <= data.
  - Read: the port's read_data register <= mem[addr], reflecting all writes committed at earlier edges.
  - The port moves to LAT; with LATENCY=1 it moves directly to DONE.
- read_data holds its captured value until that port's next grant. It is not cleared on DONE exit.
- Address and data are sampled only at the grant edge. Changes while in LAT or DONE are ignored.
- Holding valid high in DONE never causes a second access. A new request requires valid to fall and return to IDLE first.
- Requesters in LAT or DONE are never pending, so they are skipped by the arbiter.
- The array is not reset and its contents are undefined until written. Reset does not alter array contents.

## Timing

- Reset values:
  - all ready outputs 0
  - all read_data 0
  - all FSMs IDLE
  - rr_ptr 0
  - Reset assertion mid-operation forces these values immediately and asynchronously.
  - Accesses that were granted before reset remain committed in the array. Ungranted accesses are dropped.
- Uncontended latency: valid first high in cycle t gives grant edge at the end of cycle t, and ready high from cycle t+LATENCY.
- Ready deassertion: valid low in cycle u while in DONE gives ready low in cycle u+1. The port can be granted again, at the earliest, at the end of cycle u+1.
- Same-address write and read granted in different cycles: strict grant order defines the result. No bypass within a single cycle is needed, because only one access occurs per cycle.
- Fairness bound: a pending requester is granted within 2*NUM_CHANNELS cycles of becoming pending.
- Throughput: one access per cycle in aggregate, regardless of channel mix.

## Test plan

- Reset check: hold reset=0 with random valids. All ready and read_data must be 0 and the array untouched; after release with no valids, outputs remain 0.
- Single write then read (LATENCY=2):
  - ch0 writes 0xDEADBEEF to addr 0x10, valid from cycle 0: write_ready[0]=1 in cycle 2. Drop valid in cycle 3: ready=0 in cycle 4.
  - ch3 then reads addr 0x10: read_ready[3] rises 2 cycles after valid, with data 0xDEADBEEF.
- Contention: after reset, all 8 read valids rise in the same cycle 0. Grants go in order ch0..ch7, one per cycle. read_ready[c] rises in cycle c+2 and each is held until its valid drops.
- Write/read ordering on one channel: after reset, ch1 asserts write (addr 0x20, data 0x12345678) and read (addr 0x20) in the same cycle. Write index 2 is granted before read index 3, so read_data[1] is 0x12345678, with the write ready in cycle 2 and the read ready in cycle 3.
- Hold and abort:
  - Keep write_valid[2] high for 10 cycles after ready while changing write_data. Only one array update (the original data) may occur, and ready stays 1 throughout.
  - Assert reset while read ch4 is in LAT: read_ready[4] must go to 0 immediately and stay 0 until the request is re-issued after reset release.
- Fairness: ch0 re-issues writes back-to-back while all other ports stay busy. Read ch5, pending at cycle 0, must be granted by cycle 15 (NUM_CHANNELS=8).

Source files
------------

// File: rtl/data_mem_responder.sv
// Multi-channel data-memory responder: a round-robin arbiter grants one read or
// write per cycle into a single-ported word array and answers with a fixed-latency ready.
`timescale 1ns/1ps
module data_mem_responder #(
  parameter int NUM_CHANNELS = 8,
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 32,
  parameter int LATENCY      = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CHANNELS-1:0] data_mem_read_valid,
  input  logic [ADDR_WIDTH-1:0]   data_mem_read_address [NUM_CHANNELS],
  output logic [NUM_CHANNELS-1:0] data_mem_read_ready,
  output logic [DATA_WIDTH-1:0]   data_mem_read_data [NUM_CHANNELS],
  input  logic [NUM_CHANNELS-1:0] data_mem_write_valid,
  input  logic [ADDR_WIDTH-1:0]   data_mem_write_address [NUM_CHANNELS],
  input  logic [DATA_WIDTH-1:0]   data_mem_write_data [NUM_CHANNELS],
  output logic [NUM_CHANNELS-1:0] data_mem_write_ready
);
  localparam int NREQ  = 2 * NUM_CHANNELS;
  localparam int PW    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [3:0] LAT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] { IDLE, LAT, DONE } req_state_t;

  req_state_t            state     [NREQ];
  req_state_t            state_nxt [NREQ];
  logic [3:0]            cnt       [NREQ];
  logic [3:0]            cnt_nxt   [NREQ];
  logic [PW-1:0]         rr_ptr;
  logic [PW-1:0]         rr_ptr_nxt;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       pending;
  logic                  grant_vld;
  logic [PW-1:0]         grant_idx;
  logic [PW:0]           scan;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Requester 2c is the write port of channel c, 2c+1 its read port.
  always_comb begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      req_valid[2*c]   = data_mem_write_valid[c];
      req_valid[2*c+1] = data_mem_read_valid[c];
    end
  end

  // Nothing is pending while reset is held, so the array cannot change then.
  always_comb begin
    for (int i = 0; i < NREQ; i++)
      pending[i] = reset && req_valid[i] && (state[i] == IDLE);
  end

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    scan      = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan = {1'b0, rr_ptr} + (PW+1)'(k);
      if (scan >= (PW+1)'(NREQ))
        scan = scan - (PW+1)'(NREQ);
      if (!grant_vld && pending[scan[PW-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = scan[PW-1:0];
      end
    end
  end

  always_comb begin
    rr_ptr_nxt = rr_ptr;
    if (grant_vld)
      rr_ptr_nxt = (grant_idx == PW'(NREQ - 1)) ? '0 : grant_idx + PW'(1);
  end

  // LAT ends when the decremented count reaches 0, so ready rises LATENCY
  // cycles after the grant edge.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      state_nxt[i] = state[i];
      cnt_nxt[i]   = cnt[i];
      case (state[i])
        IDLE: begin
          if (grant_vld && grant_idx == PW'(i)) begin
            state_nxt[i] = (LATENCY == 1) ? DONE : LAT;
            cnt_nxt[i]   = LAT_INIT;
          end
        end
        LAT: begin
          cnt_nxt[i] = cnt[i] - 4'd1;
          if (cnt[i] <= 4'd1)
            state_nxt[i] = DONE;
        end
        DONE: begin
          if (!req_valid[i])
            state_nxt[i] = IDLE;
        end
        default: state_nxt[i] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr <= '0;
      for (int i = 0; i < NREQ; i++) begin
        state[i] <= IDLE;
        cnt[i]   <= '0;
      end
    end else begin
      rr_ptr <= rr_ptr_nxt;
      for (int i = 0; i < NREQ; i++) begin
        state[i] <= state_nxt[i];
        cnt[i]   <= cnt_nxt[i];
      end
    end
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (grant_vld && grant_idx == PW'(2*c)) begin
        wr_en   = 1'b1;
        wr_addr = data_mem_write_address[c];
        wr_data = data_mem_write_data[c];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_addr] <= wr_data;
  end

  // Read data is captured at grant and held until that port's next grant.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < NUM_CHANNELS; c++)
        data_mem_read_data[c] <= '0;
    end else begin
      for (int c = 0; c < NUM_CHANNELS; c++)
        if (grant_vld && grant_idx == PW'(2*c+1))
          data_mem_read_data[c] <= mem[data_mem_read_address[c]];
    end
  end

  always_comb begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      data_mem_write_ready[c] = (state[2*c] == DONE);
      data_mem_read_ready[c]  = (state[2*c+1] == DONE);
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: requests push expectations, a monitor
// pops them on each ready rise and replays accesses on a plain array model.
`timescale 1ns/1ps
module tb_data_mem_responder;
  localparam int NC  = 8;
  localparam int AW  = 8;
  localparam int DW  = 32;
  localparam int LAT = 2;
  localparam int NP  = 2 * NC;

  logic          clk = 1'b0;
  logic          reset;
  logic [NC-1:0] rd_valid, rd_ready, wr_valid, wr_ready;
  logic [AW-1:0] rd_addr [NC];
  logic [DW-1:0] rd_data [NC];
  logic [AW-1:0] wr_addr [NC];
  logic [DW-1:0] wr_data [NC];

  data_mem_responder #(
    .NUM_CHANNELS(NC), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LATENCY(LAT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .data_mem_read_valid(rd_valid),
    .data_mem_read_address(rd_addr),
    .data_mem_read_ready(rd_ready),
    .data_mem_read_data(rd_data),
    .data_mem_write_valid(wr_valid),
    .data_mem_write_address(wr_addr),
    .data_mem_write_data(wr_data),
    .data_mem_write_ready(wr_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int            port;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            issue;
    int            exp_rdy;
  } req_t;

  req_t          sbq[$];
  logic [DW-1:0] model [256];
  bit            known [256];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @cycle %0d: got %0h required %0h", name, cyc, act, exp);
    end
  endtask

  function automatic bit port_ready(input int p);
    return (p % 2 == 1) ? rd_ready[p/2] : wr_ready[p/2];
  endfunction

  function automatic bit port_valid(input int p);
    return (p % 2 == 1) ? rd_valid[p/2] : wr_valid[p/2];
  endfunction

  task automatic set_req(input int p, input bit v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (p % 2 == 1) begin
      rd_valid[p/2] = v;
      rd_addr[p/2]  = a;
    end else begin
      wr_valid[p/2] = v;
      wr_addr[p/2]  = a;
      wr_data[p/2]  = d;
    end
  endtask

  task automatic clear_inputs();
    rd_valid = '0;
    wr_valid = '0;
    for (int c = 0; c < NC; c++) begin
      rd_addr[c] = '0;
      wr_addr[c] = '0;
      wr_data[c] = '0;
    end
  endtask

  // Reset held with random request noise; address 0x10 is targeted often so a
  // write leaking through reset would corrupt a word that is read back later.
  task automatic reset_noise(input int n);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (n) begin
      rd_valid = NC'($urandom);
      wr_valid = NC'($urandom);
      for (int c = 0; c < NC; c++) begin
        rd_addr[c] = AW'($urandom);
        wr_addr[c] = ($urandom_range(0, 1) == 1) ? 8'h10 : AW'($urandom);
        wr_data[c] = $urandom;
      end
      @(posedge clk); #1;
    end
    clear_inputs();
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  // exp_off < 0 selects the fairness window instead of an exact ready cycle.
  task automatic run_port(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input int delay, input int exp_off, input int hold);
    req_t e;
    int   n;
    repeat (delay + 1) @(posedge clk);
    #1;
    e.port    = p;
    e.addr    = a;
    e.data    = d;
    e.issue   = cyc;
    e.exp_rdy = (exp_off < 0) ? -1 : cyc + exp_off;
    sbq.push_back(e);
    set_req(p, 1'b1, a, d);
    n = 0;
    while (!port_ready(p) && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 40) begin
      total++;
      bad++;
      $display("FAIL ready_timeout port %0d: got no ready in 40 cycles, required ready", p);
    end
    repeat (hold) begin
      @(posedge clk); #1;
      if (p % 2 == 1) rd_addr[p/2] = AW'($urandom);
      else            wr_data[p/2] = $urandom;
    end
    @(posedge clk); #1;
    set_req(p, 1'b0, a, d);
  endtask

  task automatic port_rand(input int p, input int n, input bit greedy);
    for (int i = 0; i < n; i++)
      run_port(p, AW'(8'h10 + $urandom_range(0, 7)), $urandom,
               greedy ? 0 : $urandom_range(0, 3), -1,
               greedy ? 0 : $urandom_range(0, 4));
  endtask

  // Request issued, then reset asserted after 'wait_cyc' cycles (LAT or DONE).
  task automatic abort(input int p, input int wait_cyc);
    @(posedge clk); #1;
    set_req(p, 1'b1, 8'h10, '0);
    repeat (wait_cyc) @(posedge clk);
    #1;
    reset = 1'b0;
    set_req(p, 1'b0, 8'h10, '0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic handle_rise(input int p);
    req_t e;
    int   idx;
    int   dly;
    idx = -1;
    foreach (sbq[i])
      if (idx < 0 && sbq[i].port == p) idx = i;
    if (idx < 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_ready port %0d @cycle %0d: got ready 1 required 0", p, cyc);
      return;
    end
    e = sbq[idx];
    sbq.delete(idx);
    if (e.exp_rdy >= 0) begin
      check($sformatf("ready_cycle_p%0d", p), 64'(cyc), 64'(e.exp_rdy));
    end else begin
      dly = cyc - e.issue;
      total++;
      if (dly < LAT || dly > 2*NC - 1 + LAT) begin
        bad++;
        $display("FAIL fairness_p%0d: got ready after %0d cycles, required %0d..%0d",
                 p, dly, LAT, 2*NC - 1 + LAT);
      end
    end
    if (p % 2 == 0) begin
      model[e.addr] = e.data;
      known[e.addr] = 1'b1;
    end else if (known[e.addr]) begin
      check($sformatf("read_data_ch%0d_a%0h", p/2, e.addr), 64'(rd_data[p/2]), 64'(model[e.addr]));
    end
  endtask

  initial begin : monitor
    bit prv_r [NP];
    bit prv_v [NP];
    bit r;
    bit v;
    int rises;
    for (int p = 0; p < NP; p++) begin
      prv_r[p] = 1'b0;
      prv_v[p] = 1'b0;
    end
    forever begin
      @(negedge clk);
      if (reset !== 1'b1) begin
        for (int c = 0; c < NC; c++) begin
          check("reset_rd_ready", 64'(rd_ready[c]), 64'(0));
          check("reset_wr_ready", 64'(wr_ready[c]), 64'(0));
          check("reset_rd_data", 64'(rd_data[c]), 64'(0));
        end
        sbq.delete();
        for (int p = 0; p < NP; p++) begin
          prv_r[p] = 1'b0;
          prv_v[p] = 1'b0;
        end
      end else begin
        rises = 0;
        for (int p = 0; p < NP; p++) begin
          r = port_ready(p);
          v = port_valid(p);
          if (prv_r[p]) begin
            check(prv_v[p] ? "ready_hold" : "ready_drop", 64'(r), 64'(prv_v[p]));
          end else if (r) begin
            rises++;
            handle_rise(p);
          end
          prv_r[p] = r;
          prv_v[p] = v;
        end
        if (rises > 0) check("one_access_per_cycle", 64'(rises), 64'(1));
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no completion, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    reset = 1'b0;
    clear_inputs();
    for (int a = 0; a < 256; a++) begin
      model[a] = '0;
      known[a] = 1'b0;
    end
    reset_noise(5);
    repeat (2) @(posedge clk);

    // Single write on ch0 then read on ch3
    run_port(0, 8'h10, 32'hDEADBEEF, 0, LAT, 0);
    run_port(7, 8'h10, 32'h0, 1, LAT, 0);

    // Reset with noise must not touch the array; then all reads contend
    reset_noise(4);
    for (int c = 0; c < NC; c++) begin
      automatic int cc = c;
      fork
        run_port(2*cc + 1, 8'h10, 32'h0, 0, LAT + cc, 2);
      join_none
    end
    wait fork;

    // Write and read of the same channel in the same cycle
    reset_noise(3);
    fork
      run_port(2, 8'h20, 32'h12345678, 0, LAT, 0);
      run_port(3, 8'h20, 32'h0, 0, LAT + 1, 0);
    join

    // Long hold with changing write data: single array update
    run_port(4, 8'h30, 32'hCAFEF00D, 0, LAT, 10);
    run_port(5, 8'h30, 32'h0, 0, LAT, 0);

    // Reset while read ch4 is in LAT, then while in DONE
    abort(9, 1);
    run_port(9, 8'h10, 32'h0, 1, LAT, 0);
    abort(9, 2);
    run_port(9, 8'h10, 32'h0, 1, LAT, 0);

    // Randomized traffic with a greedy ch0 writer
    reset_noise(2);
    for (int p = 0; p < NP; p++) begin
      automatic int pp = p;
      fork
        port_rand(pp, (pp == 0) ? 30 : 15, pp == 0);
      join_none
    end
    wait fork;

    repeat (4) @(posedge clk);
    check("scoreboard_drained", 64'(sbq.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
